// File: rtl/iob_eth_rx_sched.sv
//------------------------------------------------------------------------------
// Module   : iob_eth_rx_sched
// Brief    : Ethernet RX frame-buffer scheduler. Steers incoming frames into
//            one of two ping-pong buffer banks, drops frames when no bank is
//            free or the CRC fails, and hands completed frames to the host in
//            arrival order through an avail/ack handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iob_eth_rx_sched #(
  parameter int NBYTES_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  // frame receiver side
  input  logic                rx_enable_i,
  input  logic                rx_start_i,
  input  logic                rx_wr_i,
  input  logic                rx_done_i,
  input  logic [NBYTES_W-1:0] rx_nbytes_i,
  input  logic                rx_crc_ok_i,
  // frame buffer side
  output logic                buf_wr_en_o,
  output logic                buf_wr_bank_o,
  output logic                buf_rd_bank_o,
  // host side
  output logic                frame_avail_o,
  output logic [NBYTES_W-1:0] frame_nbytes_o,
  input  logic                frame_ack_i,
  // statistics
  output logic [CNT_W-1:0]    drop_cnt_o,
  output logic [CNT_W-1:0]    crc_err_cnt_o
);

  // Write-side FSM: idle between frames, receiving into a bank, or
  // swallowing a frame that had no free bank.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Per-bank lifecycle: FREE -> FILL (being written) -> READY (host owns it).
  typedef enum logic [1:0] {
    BK_FREE  = 2'd0,
    BK_FILL  = 2'd1,
    BK_READY = 2'd2
  } bank_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t              state_q,       state_d;
  bank_t               bank_q [2];
  bank_t               bank_d [2];
  logic [NBYTES_W-1:0] len_q  [2];
  logic [NBYTES_W-1:0] len_d  [2];
  logic                wr_bank_q,     wr_bank_d;
  logic                rd_bank_q,     rd_bank_d;
  logic [CNT_W-1:0]    drop_cnt_q,    drop_cnt_d;
  logic [CNT_W-1:0]    crc_err_cnt_q, crc_err_cnt_d;

  logic                ack_fire;

  // A host ack only counts when the read bank actually holds a frame.
  assign ack_fire = frame_ack_i & (bank_q[rd_bank_q] == BK_READY);

  // Next-state logic for the write FSM, bank status, lengths, pointers and
  // counters. Write-side updates only touch a FREE or FILL bank while the
  // ack only touches a READY bank, so both can apply in the same cycle
  // without colliding.
  always_comb begin
    state_d       = state_q;
    bank_d[0]     = bank_q[0];
    bank_d[1]     = bank_q[1];
    len_d[0]      = len_q[0];
    len_d[1]      = len_q[1];
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    drop_cnt_d    = drop_cnt_q;
    crc_err_cnt_d = crc_err_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // A stray rx_done in IDLE is ignored and also masks a coincident
        // rx_start, so a frame never begins on the same edge one ends.
        if (rx_start_i && rx_enable_i && !rx_done_i) begin
          if (bank_q[wr_bank_q] == BK_FREE) begin
            bank_d[wr_bank_q] = BK_FILL;
            state_d           = ST_RECV;
          end else begin
            state_d = ST_DROP;
            if (drop_cnt_q != C_CNT_MAX) begin
              drop_cnt_d = drop_cnt_q + 1'b1;
            end
          end
        end
      end

      ST_RECV: begin
        // rx_start without rx_done means the receiver restarted an aborted
        // frame; keep filling the same bank from scratch.
        if (rx_done_i) begin
          state_d = ST_IDLE;
          if (rx_crc_ok_i) begin
            bank_d[wr_bank_q] = BK_READY;
            len_d[wr_bank_q]  = rx_nbytes_i;
            wr_bank_d         = ~wr_bank_q;
          end else begin
            bank_d[wr_bank_q] = BK_FREE;
            if (crc_err_cnt_q != C_CNT_MAX) begin
              crc_err_cnt_d = crc_err_cnt_q + 1'b1;
            end
          end
        end
      end

      ST_DROP: begin
        if (rx_done_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ack_fire) begin
      bank_d[rd_bank_q] = BK_FREE;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // State register with synchronous reset that discards any frames in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bank_q[0]     <= BK_FREE;
      bank_q[1]     <= BK_FREE;
      len_q[0]      <= '0;
      len_q[1]      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      drop_cnt_q    <= '0;
      crc_err_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      bank_q[0]     <= bank_d[0];
      bank_q[1]     <= bank_d[1];
      len_q[0]      <= len_d[0];
      len_q[1]      <= len_d[1];
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      drop_cnt_q    <= drop_cnt_d;
      crc_err_cnt_q <= crc_err_cnt_d;
    end
  end

  // Outputs: write enable is gated with zero latency, everything else comes
  // straight from registers.
  assign buf_wr_en_o    = rx_wr_i & (state_q == ST_RECV);
  assign buf_wr_bank_o  = wr_bank_q;
  assign buf_rd_bank_o  = rd_bank_q;
  assign frame_avail_o  = (bank_q[rd_bank_q] == BK_READY);
  assign frame_nbytes_o = len_q[rd_bank_q];
  assign drop_cnt_o     = drop_cnt_q;
  assign crc_err_cnt_o  = crc_err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_iob_eth_rx_sched.sv
//------------------------------------------------------------------------------
// Module   : tb_iob_eth_rx_sched
// Brief    : Directed self-checking bench for iob_eth_rx_sched. Counters are
//            built 3 bits wide so that saturation is reachable quickly.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iob_eth_rx_sched;

  localparam int NBYTES_W = 16;
  localparam int CNT_W    = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                rx_enable = 1'b1;
  logic                rx_start = 1'b0;
  logic                rx_wr = 1'b0;
  logic                rx_done = 1'b0;
  logic [NBYTES_W-1:0] rx_nbytes = '0;
  logic                rx_crc_ok = 1'b0;
  logic                buf_wr_en;
  logic                buf_wr_bank;
  logic                buf_rd_bank;
  logic                frame_avail;
  logic [NBYTES_W-1:0] frame_nbytes;
  logic                frame_ack = 1'b0;
  logic [CNT_W-1:0]    drop_cnt;
  logic [CNT_W-1:0]    crc_err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  iob_eth_rx_sched #(.NBYTES_W(NBYTES_W), .CNT_W(CNT_W)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .rx_enable_i    (rx_enable),
    .rx_start_i     (rx_start),
    .rx_wr_i        (rx_wr),
    .rx_done_i      (rx_done),
    .rx_nbytes_i    (rx_nbytes),
    .rx_crc_ok_i    (rx_crc_ok),
    .buf_wr_en_o    (buf_wr_en),
    .buf_wr_bank_o  (buf_wr_bank),
    .buf_rd_bank_o  (buf_rd_bank),
    .frame_avail_o  (frame_avail),
    .frame_nbytes_o (frame_nbytes),
    .frame_ack_i    (frame_ack),
    .drop_cnt_o     (drop_cnt),
    .crc_err_cnt_o  (crc_err_cnt)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    rx_start = 1'b1;
    step();
    rx_start = 1'b0;
  endtask

  // Issue nwr byte writes; return how many were passed to the given bank.
  task automatic writes(input int nwr, input logic bank, output int seen);
    seen = 0;
    for (int i = 0; i < nwr; i++) begin
      rx_wr = 1'b1;
      #1;
      if (buf_wr_en && (buf_wr_bank == bank)) seen++;
      step();
    end
    rx_wr = 1'b0;
  endtask

  task automatic done_pulse(input logic [NBYTES_W-1:0] len, input logic ok);
    rx_nbytes = len;
    rx_crc_ok = ok;
    rx_done   = 1'b1;
    step();
    rx_done   = 1'b0;
    rx_crc_ok = 1'b0;
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  // Complete frame: start, nwr writes, done. Checks that exactly exp_en of
  // the writes reached the buffer on bank exp_bank.
  task automatic frame(input string tag, input int nwr, input logic [NBYTES_W-1:0] len,
                       input logic ok, input int exp_en, input logic exp_bank);
    int seen;
    start_pulse();
    writes(nwr, exp_bank, seen);
    check(tag, seen, exp_en);
    done_pulse(len, ok);
  endtask

  initial begin
    int seen;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_avail",   frame_avail,  0);
    check("rst_nbytes",  frame_nbytes, 0);
    check("rst_wr_bank", buf_wr_bank,  0);
    check("rst_rd_bank", buf_rd_bank,  0);
    check("rst_drop",    drop_cnt,     0);
    check("rst_crc",     crc_err_cnt,  0);
    rx_wr = 1'b1; #1;
    check("rst_wr_en", buf_wr_en, 0);
    rx_wr = 1'b0;

    // ---------------- single good frame ----------------
    frame("f1_wr_en", 64, 16'd50, 1'b1, 64, 1'b0);
    check("f1_avail",   frame_avail,  1);
    check("f1_nbytes",  frame_nbytes, 50);
    check("f1_wr_bank", buf_wr_bank,  1);
    ack_pulse();
    check("f1_ack_avail", frame_avail, 0);
    check("f1_rd_bank",   buf_rd_bank, 1);

    // ---------------- three frames, no ack ----------------
    do_reset();
    frame("b2b_a_wr", 10, 16'd46,   1'b1, 10, 1'b0);
    frame("b2b_b_wr", 10, 16'd100,  1'b1, 10, 1'b1);
    frame("b2b_c_wr", 10, 16'd1500, 1'b1, 0,  1'b0);
    rx_wr = 1'b1; #1;
    check("b2b_c_any_en", buf_wr_en, 0);
    rx_wr = 1'b0;
    check("b2b_drop", drop_cnt, 1);
    check("b2b_avail0", frame_avail,  1);
    check("b2b_len0",   frame_nbytes, 46);
    ack_pulse();
    check("b2b_len1",   frame_nbytes, 100);
    check("b2b_rd1",    buf_rd_bank,  1);
    ack_pulse();
    check("b2b_empty",  frame_avail,  0);
    check("b2b_crc",    crc_err_cnt,  0);

    // ---------------- bad CRC then good frame ----------------
    do_reset();
    frame("crc_bad_wr", 8, 16'd55, 1'b0, 8, 1'b0);
    check("crc_cnt",     crc_err_cnt, 1);
    check("crc_avail",   frame_avail, 0);
    check("crc_wr_bank", buf_wr_bank, 0);
    frame("crc_next_wr", 8, 16'd60, 1'b1, 8, 1'b0);
    check("crc_next_avail", frame_avail,  1);
    check("crc_next_len",   frame_nbytes, 60);
    check("crc_next_drop",  drop_cnt,     0);

    // ---------------- rx_done and ack in the same cycle ----------------
    do_reset();
    frame("sc_x_wr", 4, 16'd33, 1'b1, 4, 1'b0);
    ack_pulse();
    frame("sc_y_wr", 4, 16'd70, 1'b1, 4, 1'b1);
    check("sc_pre_rd",  buf_rd_bank,  1);
    check("sc_pre_len", frame_nbytes, 70);
    start_pulse();
    writes(6, 1'b0, seen);
    check("sc_z_wr", seen, 6);
    rx_nbytes = 16'd80;
    rx_crc_ok = 1'b1;
    rx_done   = 1'b1;
    frame_ack = 1'b1;
    step();
    rx_done   = 1'b0;
    rx_crc_ok = 1'b0;
    frame_ack = 1'b0;
    check("sc_rd",      buf_rd_bank,  0);
    check("sc_avail",   frame_avail,  1);
    check("sc_len",     frame_nbytes, 80);
    check("sc_wr_bank", buf_wr_bank,  1);
    // bank 1 must be free again: a new frame is accepted into it
    frame("sc_b1_free_wr", 3, 16'd90, 1'b1, 3, 1'b1);
    check("sc_drop", drop_cnt, 0);

    // ---------------- rx_enable handling ----------------
    do_reset();
    rx_enable = 1'b0;
    frame("en_off_wr", 5, 16'd12, 1'b1, 0, 1'b0);
    check("en_off_avail", frame_avail, 0);
    check("en_off_drop",  drop_cnt,    0);
    check("en_off_crc",   crc_err_cnt, 0);
    check("en_off_wrbk",  buf_wr_bank, 0);
    rx_enable = 1'b1;
    start_pulse();
    writes(2, 1'b0, seen);
    rx_enable = 1'b0;
    begin
      int seen2;
      writes(3, 1'b0, seen2);
      check("en_mid_wr", seen + seen2, 5);
    end
    done_pulse(16'd20, 1'b1);
    rx_enable = 1'b1;
    check("en_mid_avail", frame_avail,  1);
    check("en_mid_len",   frame_nbytes, 20);

    // ---------------- reset mid-frame ----------------
    frame("rm_b1_wr", 2, 16'd40, 1'b1, 2, 1'b1);
    frame("rm_drop_wr", 2, 16'd41, 1'b1, 0, 1'b0);
    check("rm_drop_pre", drop_cnt, 1);
    ack_pulse();
    ack_pulse();
    frame("rm_bad_wr", 2, 16'd42, 1'b0, 2, 1'b0);
    check("rm_crc_pre", crc_err_cnt, 1);
    frame("rm_ready_wr", 2, 16'd43, 1'b1, 2, 1'b0);
    start_pulse();
    writes(3, 1'b1, seen);
    rst = 1'b1;
    rx_wr = 1'b1;
    step();
    rst = 1'b0;
    check("rm_avail",  frame_avail, 0);
    check("rm_wrbank", buf_wr_bank, 0);
    check("rm_rdbank", buf_rd_bank, 0);
    check("rm_drop",   drop_cnt,    0);
    check("rm_crc",    crc_err_cnt, 0);
    check("rm_wr_en",  buf_wr_en,   0);
    rx_wr = 1'b0;

    // ---------------- drop counter saturation ----------------
    frame("sat_a_wr", 1, 16'd1, 1'b1, 1, 1'b0);
    frame("sat_b_wr", 1, 16'd2, 1'b1, 1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      start_pulse();
      done_pulse(16'd3, 1'b1);
    end
    check("sat_max", drop_cnt, 7);
    for (int i = 0; i < 2; i++) begin
      start_pulse();
      done_pulse(16'd3, 1'b1);
    end
    check("sat_hold",   drop_cnt,     7);
    check("sat_len",    frame_nbytes, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
